// File: rtl/xmit_pkg.sv
// Shared types and constants for the transmit frame scheduler.
package xmit_pkg;

    localparam int unsigned LEN_W_DFLT   = 12;
    localparam int unsigned MAX_LEN_DFLT = 1518;

    localparam logic SEL_HI = 1'b1;
    localparam logic SEL_LO = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        GAP  = 2'd2
    } xmit_state_e;

endpackage

// File: rtl/xmit_prio_sched_if.sv
// Descriptor-queue and byte-read handshake bundle for xmit_prio_sched.
interface xmit_prio_sched_if #(
    parameter int unsigned LEN_W = xmit_pkg::LEN_W_DFLT
);
    logic             hi_desc_valid;
    logic [LEN_W-1:0] hi_desc_len;
    logic             hi_desc_pop;
    logic             lo_desc_valid;
    logic [LEN_W-1:0] lo_desc_len;
    logic             lo_desc_pop;
    logic             tx_ready;
    logic             rd_en;
    logic             rd_sel;
    logic             sof;
    logic             eof;
    logic             frame_active;
    logic             discard;

    modport master (
        input  hi_desc_valid, hi_desc_len, lo_desc_valid, lo_desc_len, tx_ready,
        output hi_desc_pop, lo_desc_pop, rd_en, rd_sel, sof, eof, frame_active, discard
    );

    modport slave (
        output hi_desc_valid, hi_desc_len, lo_desc_valid, lo_desc_len, tx_ready,
        input  hi_desc_pop, lo_desc_pop, rd_en, rd_sel, sof, eof, frame_active, discard
    );
endinterface

// File: rtl/xmit_wprio_arb.sv
// Weighted-priority select between high and low queues, with the high-run counter.
module xmit_wprio_arb
    import xmit_pkg::*;
#(
    parameter int unsigned HI_WEIGHT = 10
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic arb_en,
    input  logic hi_valid,
    input  logic lo_valid,
    input  logic legal,
    output logic grant,
    output logic grant_sel
);
    localparam logic [7:0] HiWeight = 8'(HI_WEIGHT);

    logic [7:0] hi_run_q, hi_run_d;

    assign grant     = arb_en && (hi_valid || lo_valid);
    assign grant_sel = (lo_valid && (!hi_valid || hi_run_q == HiWeight)) ? SEL_LO : SEL_HI;

    // Only legal grants move the run counter; discards leave it alone.
    always_comb begin
        hi_run_d = hi_run_q;
        if (grant && legal) begin
            if (grant_sel == SEL_HI && lo_valid) begin
                hi_run_d = (hi_run_q == HiWeight) ? hi_run_q : hi_run_q + 8'd1;
            end else begin
                hi_run_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hi_run_q <= 8'd0;
        end else begin
            hi_run_q <= hi_run_d;
        end
    end
endmodule

// File: rtl/xmit_prio_sched.sv
// Transmit frame scheduler: arbitrates queues, sequences byte reads, inserts the IFG.
// Optional statistics counters are enabled by defining XMIT_SCHED_STATS_EN.
module xmit_prio_sched
    import xmit_pkg::*;
#(
    parameter int unsigned LEN_W      = LEN_W_DFLT,
    parameter int unsigned MAX_LEN    = MAX_LEN_DFLT,
    parameter int unsigned HI_WEIGHT  = 10,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic               clk_sys,
    input  logic               reset,
    xmit_prio_sched_if.master  bus
`ifdef XMIT_SCHED_STATS_EN
    ,
    output logic [15:0]        hi_frame_cnt,
    output logic [15:0]        lo_frame_cnt,
    output logic [15:0]        discard_cnt
`endif
);
    localparam logic [15:0] GapLast = (IFG_CYCLES == 0) ? 16'd0 : 16'(IFG_CYCLES - 1);

    xmit_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      gap_q, gap_d;
    logic             sel_q, sel_d;
    logic [LEN_W-1:0] sel_len;
    logic             arb_en, grant, grant_sel, legal;
    logic             hi_pop, lo_pop, rd_en, sof, eof, discard;

    // Holding arbitration off during reset keeps every output low while reset is asserted.
    assign arb_en  = (state_q == IDLE) && !reset;
    assign sel_len = (grant_sel == SEL_HI) ? bus.hi_desc_len : bus.lo_desc_len;
    assign legal   = (sel_len != '0) && (32'(sel_len) <= MAX_LEN);

    xmit_wprio_arb #(
        .HI_WEIGHT (HI_WEIGHT)
    ) u_arb (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .arb_en    (arb_en),
        .hi_valid  (bus.hi_desc_valid),
        .lo_valid  (bus.lo_desc_valid),
        .legal     (legal),
        .grant     (grant),
        .grant_sel (grant_sel)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        hi_pop  = 1'b0;
        lo_pop  = 1'b0;
        rd_en   = 1'b0;
        sof     = 1'b0;
        eof     = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    hi_pop = (grant_sel == SEL_HI);
                    lo_pop = (grant_sel == SEL_LO);
                    len_d  = sel_len;
                    sel_d  = grant_sel;
                    cnt_d  = '0;
                    if (legal) begin
                        state_d = XMIT;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            XMIT: begin
                rd_en = bus.tx_ready;
                if (rd_en) begin
                    sof = (cnt_q == '0);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        eof     = 1'b1;
                        cnt_d   = '0;
                        gap_d   = '0;
                        state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            sel_q   <= SEL_LO;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.hi_desc_pop  = hi_pop;
    assign bus.lo_desc_pop  = lo_pop;
    assign bus.rd_en        = rd_en;
    assign bus.rd_sel       = sel_q;
    assign bus.sof          = sof;
    assign bus.eof          = eof;
    assign bus.frame_active = (state_q == XMIT);
    assign bus.discard      = discard;

`ifdef XMIT_SCHED_STATS_EN
    logic [15:0] hi_frame_cnt_q, lo_frame_cnt_q, discard_cnt_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hi_frame_cnt_q <= 16'd0;
            lo_frame_cnt_q <= 16'd0;
            discard_cnt_q  <= 16'd0;
        end else if (grant) begin
            if (!legal) begin
                discard_cnt_q <= discard_cnt_q + 16'd1;
            end else if (grant_sel == SEL_HI) begin
                hi_frame_cnt_q <= hi_frame_cnt_q + 16'd1;
            end else begin
                lo_frame_cnt_q <= lo_frame_cnt_q + 16'd1;
            end
        end
    end

    assign hi_frame_cnt = hi_frame_cnt_q;
    assign lo_frame_cnt = lo_frame_cnt_q;
    assign discard_cnt  = discard_cnt_q;
`endif
endmodule

// File: tb/tb_xmit_prio_sched.sv
// Directed bench for xmit_prio_sched; inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_xmit_prio_sched;
    logic clk_sys = 1'b0;
    logic reset;

    always #5 clk_sys = ~clk_sys;

    xmit_prio_sched_if bus ();

`ifdef XMIT_SCHED_STATS_EN
    logic [15:0] hi_frame_cnt, lo_frame_cnt, discard_cnt;
`endif

    xmit_prio_sched dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus)
`ifdef XMIT_SCHED_STATS_EN
        ,
        .hi_frame_cnt (hi_frame_cnt),
        .lo_frame_cnt (lo_frame_cnt),
        .discard_cnt  (discard_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    int grants[$];
    int pop_t[$];
    int frame_rd[$];
    int frame_sof[$];
    int frame_sel[$];
    int cur_rd = 0;
    int cur_sof = 0;
    int hi_sel_n = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.hi_desc_pop, bus.lo_desc_pop, bus.rd_en, bus.rd_sel,
                bus.sof, bus.eof, bus.frame_active, bus.discard};
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        grants.delete();
        pop_t.delete();
        frame_rd.delete();
        frame_sof.delete();
        frame_sel.delete();
        cur_rd = 0;
        cur_sof = 0;
        hi_sel_n = 0;
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int k = 0;
        while (grants.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, (grants.size() >= n) ? 1 : 0, 1);
    endtask

    // Passive monitor: logs pops, per-frame byte/sof counts and select at eof.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (bus.hi_desc_pop) begin grants.push_back(1); pop_t.push_back(cyc); end
            if (bus.lo_desc_pop) begin grants.push_back(0); pop_t.push_back(cyc); end
            if (bus.rd_en) begin
                cur_rd++;
                if (bus.sof) cur_sof++;
            end
            if (bus.eof) begin
                frame_rd.push_back(cur_rd);
                frame_sof.push_back(cur_sof);
                frame_sel.push_back(int'(bus.rd_sel));
                cur_rd = 0;
                cur_sof = 0;
            end
            if (bus.frame_active && bus.rd_sel) hi_sel_n++;
            cyc++;
        end
    end

    initial begin
        logic [6:0] rdv, sofv, eofv, actv;
        logic [6:0] exp_rd, exp_sof, exp_eof;
        int k;

        reset = 1'b1;
        bus.hi_desc_valid = 1'b0;
        bus.hi_desc_len   = '0;
        bus.lo_desc_valid = 1'b0;
        bus.lo_desc_len   = '0;
        bus.tx_ready      = 1'b1;
        step_n(2);

        // Reset state, including a valid descriptor present during reset
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd8;
        @(negedge clk_sys);
        check_eq("reset_outs", outs(), 8'h00);
        step();
        reset = 1'b0;
        bus.hi_desc_valid = 1'b0;
        step_n(3);

        // Both queues valid, 512-byte frames: 10 high then 1 low
        clear_log();
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd512;
        bus.lo_desc_valid = 1'b1;
        bus.lo_desc_len   = 12'd512;
        k = 0;
        while (!(grants.size() == 12 && cur_rd == 99) && k < 7000) begin
            step();
            k++;
        end
        check_eq("wprio_reach_byte100", (k < 7000) ? 1 : 0, 1);
        for (int i = 0; i < 10; i++) check_eq($sformatf("wprio_grant%0d_hi", i), grants[i], 1);
        check_eq("wprio_grant10_lo", grants[10], 0);
        check_eq("wprio_grant11_hi", grants[11], 1);
        check_eq("wprio_frames_done", frame_rd.size(), 11);
        for (int i = 0; i < 11; i++) begin
            check_eq($sformatf("wprio_frame%0d_bytes", i), frame_rd[i], 512);
            check_eq($sformatf("wprio_frame%0d_sof", i), frame_sof[i], 1);
        end
        check_eq("wprio_frame0_sel", frame_sel[0], 1);
        check_eq("wprio_frame10_sel", frame_sel[10], 0);
        check_eq("wprio_pop_spacing", pop_t[1] - pop_t[0], 525);

        // Reset during byte 100 of frame 12: next cycle all outputs low
        reset = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_eq("midframe_reset_outs", outs(), 8'h00);
        step();
        reset = 1'b0;
        clear_log();
        bus.hi_desc_len = 12'd1;
        bus.lo_desc_len = 12'd1;
        wait_grants(11, 400, "post_reset_grants");
        for (int i = 0; i < 10; i++) check_eq($sformatf("post_reset_grant%0d_hi", i), grants[i], 1);
        check_eq("post_reset_grant10_lo", grants[10], 0);
        bus.hi_desc_valid = 1'b0;
        bus.lo_desc_valid = 1'b0;
        step_n(30);

        // Only low queue, 64-byte frames
        clear_log();
        bus.lo_desc_valid = 1'b1;
        bus.lo_desc_len   = 12'd64;
        wait_grants(3, 400, "lo_only_grants");
        bus.lo_desc_valid = 1'b0;
        check_eq("lo_only_spacing0", pop_t[1] - pop_t[0], 77);
        check_eq("lo_only_spacing1", pop_t[2] - pop_t[1], 77);
        check_eq("lo_only_grant0_lo", grants[0], 0);
        check_eq("lo_only_frame0_bytes", frame_rd[0], 64);
        step_n(100);
        check_eq("lo_only_rd_sel_hi_cycles", hi_sel_n, 0);

        // tx_ready toggling during a 4-byte frame
        clear_log();
        bus.lo_desc_valid = 1'b1;
        bus.lo_desc_len   = 12'd4;
        wait_grants(1, 40, "stall_grant");
        bus.lo_desc_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.tx_ready = (i % 2 == 0);
            @(negedge clk_sys);
            rdv[i]  = bus.rd_en;
            sofv[i] = bus.sof;
            eofv[i] = bus.eof;
            actv[i] = bus.frame_active;
            step();
        end
        bus.tx_ready = 1'b1;
        exp_rd  = 7'b1010101;
        exp_sof = 7'b0000001;
        exp_eof = 7'b1000000;
        check_eq("stall_rd_en", rdv, exp_rd);
        check_eq("stall_sof", sofv, exp_sof);
        check_eq("stall_eof", eofv, exp_eof);
        check_eq("stall_active", actv, 7'h7f);
        @(negedge clk_sys);
        check_eq("stall_active_after", bus.frame_active, 1'b0);
        step_n(20);

        // Illegal lengths 0 and 1519, then len 1
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd0;
        @(negedge clk_sys);
        check_eq("disc_len0", {bus.hi_desc_pop, bus.discard, bus.rd_en, bus.frame_active}, 4'b1100);
        step();
        bus.hi_desc_len = 12'd1519;
        @(negedge clk_sys);
        check_eq("disc_len1519", {bus.hi_desc_pop, bus.discard, bus.rd_en, bus.frame_active}, 4'b1100);
        step();
        bus.hi_desc_len = 12'd1;
        @(negedge clk_sys);
        check_eq("len1_pop", {bus.hi_desc_pop, bus.discard, bus.rd_en, bus.frame_active}, 4'b1000);
        step();
        bus.hi_desc_valid = 1'b0;
        @(negedge clk_sys);
        check_eq("len1_byte", {bus.rd_en, bus.sof, bus.eof, bus.frame_active, bus.rd_sel}, 5'b11111);
        step_n(20);

`ifdef XMIT_SCHED_STATS_EN
        reset = 1'b1;
        step_n(2);
        reset = 1'b0;
        clear_log();
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd1;
        wait_grants(3, 100, "stats_hi_grants");
        bus.hi_desc_valid = 1'b0;
        bus.lo_desc_valid = 1'b1;
        bus.lo_desc_len   = 12'd1;
        wait_grants(5, 100, "stats_lo_grants");
        bus.lo_desc_valid = 1'b0;
        step_n(20);
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd0;
        wait_grants(6, 10, "stats_disc_grant");
        bus.hi_desc_valid = 1'b0;
        step_n(2);
        check_eq("stats_hi_cnt", hi_frame_cnt, 3);
        check_eq("stats_lo_cnt", lo_frame_cnt, 2);
        check_eq("stats_disc_cnt", discard_cnt, 1);
        force dut.hi_frame_cnt_q = 16'hFFFF;
        step();
        release dut.hi_frame_cnt_q;
        bus.hi_desc_valid = 1'b1;
        bus.hi_desc_len   = 12'd1;
        wait_grants(7, 10, "stats_wrap_grant");
        bus.hi_desc_valid = 1'b0;
        step_n(2);
        check_eq("stats_hi_wrap", hi_frame_cnt, 0);
        step_n(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
